// File: rtl/ripple_down_monitor_pkg.sv
// Shared definitions for the ripple down-counter monitor and its testbenches.
// No logic; the state encoding is visible on the monitor's state port.
package ripple_down_monitor_pkg;

    localparam int CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

endpackage

// File: rtl/bus_sync.sv
// Per-bit N-stage synchroniser for an asynchronous bus; latency STAGES cycles.
// No backpressure; the bus is sampled every cycle.
module bus_sync
    import ripple_down_monitor_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             preset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge sys_clk or posedge preset) begin
        if (preset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ripple_down_monitor.sv
// Tracks an asynchronous ripple down-counter: sync, stability filter, wrap count, sticky fault.
// Accepted value lags a settled input by SYNC_STAGES+2 cycles; no backpressure.
module ripple_down_monitor
    import ripple_down_monitor_pkg::*;
#(
    parameter int WIDTH       = CNT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 2,
    parameter int WRAP_W      = 8
) (
    input  logic              sys_clk,
    input  logic              preset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr_fault,
    output logic [WIDTH-1:0]  value,
    output logic              value_valid,
    output logic              zero,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              fault,
    output logic [1:0]        state
);

    localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);

    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   prev;
    logic [SYNC_STAGES:0] fill;
    logic               stable;
    logic [WIDTH-1:0]   step;
    logic               legal_step;

    state_t             state_q;
    state_t             state_nxt;
    logic [WIDTH-1:0]   value_nxt;
    logic               fault_nxt;
    logic               wrap_nxt;
    logic [WRAP_W-1:0]  wrap_count_nxt;

    bus_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .sys_clk (sys_clk),
        .preset  (preset),
        .d       (cnt_in),
        .q       (s)
    );

    // fill marks when prev holds a real sample rather than reset zeros,
    // otherwise the all-zero pipeline would look like a stable count of 0.
    always_ff @(posedge sys_clk or posedge preset) begin
        if (preset) begin
            prev <= '0;
            fill <= '0;
        end else begin
            prev <= s;
            fill <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign stable     = fill[SYNC_STAGES] && (s == prev);
    assign step       = value - s;
    assign legal_step = (step != '0) && (step <= MAX_STEP_W);

    always_comb begin
        state_nxt      = state_q;
        value_nxt      = value;
        fault_nxt      = fault;
        wrap_nxt       = 1'b0;
        wrap_count_nxt = wrap_count;
        case (state_q)
            ST_ACQUIRE: begin
                if (stable) begin
                    value_nxt = s;
                    state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (stable && (s != value)) begin
                    if (legal_step) begin
                        value_nxt = s;
                        // A wrap moves value to s, so the next stable sample
                        // equals value: pulses can never be back to back.
                        if (s > value) begin
                            wrap_nxt = 1'b1;
                            if (wrap_count != '1) begin
                                wrap_count_nxt = wrap_count + WRAP_W'(1);
                            end
                        end
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    fault_nxt = 1'b0;
                    state_nxt = ST_ACQUIRE;
                end
            end
            default: state_nxt = ST_ACQUIRE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_ACQUIRE;
            value       <= '0;
            value_valid <= 1'b0;
            zero        <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            value       <= value_nxt;
            value_valid <= (state_nxt == ST_TRACK);
            zero        <= (state_nxt == ST_TRACK) && (value_nxt == '0);
            wrap_pulse  <= wrap_nxt;
            wrap_count  <= wrap_count_nxt;
            fault       <= fault_nxt;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ripple_down_monitor.sv
// Directed bench for ripple_down_monitor; a second instance with WRAP_W=2 checks saturation.
module tb_ripple_down_monitor;

    logic       sys_clk = 1'b0;
    logic       preset  = 1'b1;
    logic [5:0] cnt_in  = 6'd0;
    logic       clr_fault = 1'b0;

    logic [5:0] value;
    logic       value_valid, zero, wrap_pulse, fault;
    logic [7:0] wrap_count;
    logic [1:0] state;

    logic [5:0] value2;
    logic       value_valid2, zero2, wrap_pulse2, fault2;
    logic [1:0] wrap_count2;
    logic [1:0] state2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    ripple_down_monitor #(
        .WIDTH(6), .SYNC_STAGES(2), .MAX_STEP(2), .WRAP_W(8)
    ) dut (
        .sys_clk(sys_clk), .preset(preset), .cnt_in(cnt_in), .clr_fault(clr_fault),
        .value(value), .value_valid(value_valid), .zero(zero), .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count), .fault(fault), .state(state)
    );

    ripple_down_monitor #(
        .WIDTH(6), .SYNC_STAGES(2), .MAX_STEP(2), .WRAP_W(2)
    ) dut2 (
        .sys_clk(sys_clk), .preset(preset), .cnt_in(cnt_in), .clr_fault(clr_fault),
        .value(value2), .value_valid(value_valid2), .zero(zero2), .wrap_pulse(wrap_pulse2),
        .wrap_count(wrap_count2), .fault(fault2), .state(state2)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_preset(input logic [5:0] v);
        cnt_in = v;
        preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        cnt_in = 6'd40;
        preset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({value, value_valid, zero, wrap_pulse, wrap_count, fault, state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got value=%0d vv=%0b zero=%0b wp=%0b wc=%0d fault=%0b state=%0d, expected all 0",
                     value, value_valid, zero, wrap_pulse, wrap_count, fault, state);
        end
        preset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (value_valid !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_refill: got vv=%0b state=%0d, expected vv=0 state=0", value_valid, state);
        end
        tick();
        n_cmp++;
        if (value_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_acquire_valid: got %0b expected 1", value_valid);
        end
        n_cmp++;
        if (value !== 6'd40) begin
            n_fail++;
            $display("FAIL reset_acquire_value: got %0d expected 40", value);
        end
        n_cmp++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_acquire_state: got %0d expected 1", state);
        end
    endtask

    task automatic test_steps();
        do_preset(6'd6);
        for (int v = 5; v >= 0; v--) begin
            cnt_in = v[5:0];
            repeat (8) tick();
            n_cmp++;
            if (value !== v[5:0]) begin
                n_fail++;
                $display("FAIL steps_value: got %0d expected %0d", value, v);
            end
            n_cmp++;
            if (zero !== (v == 0)) begin
                n_fail++;
                $display("FAIL steps_zero: got %0b expected %0b at %0d", zero, (v == 0), v);
            end
            n_cmp++;
            if (fault !== 1'b0 || wrap_count !== 8'd0) begin
                n_fail++;
                $display("FAIL steps_clean: got fault=%0b wc=%0d expected 0/0", fault, wrap_count);
            end
        end
    endtask

    task automatic test_wrap();
        int pulses;
        logic last_pulse;
        pulses = 0;
        last_pulse = 1'b0;
        do_preset(6'd1);
        cnt_in = 6'd0;
        repeat (8) tick();
        n_cmp++;
        if (value !== 6'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_at_zero: got value=%0d zero=%0b expected 0/1", value, zero);
        end
        cnt_in = 6'd63;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (wrap_pulse && last_pulse) begin
                n_fail++;
                $display("FAIL wrap_pulse_width: got two consecutive pulses expected one");
            end
            if (wrap_pulse) pulses++;
            last_pulse = wrap_pulse;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL wrap_pulse_count: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (wrap_count !== 8'd1 || value !== 6'd63 || zero !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_state: got wc=%0d value=%0d zero=%0b fault=%0b expected 1/63/0/0",
                     wrap_count, value, zero, fault);
        end
    endtask

    task automatic test_unstable();
        do_preset(6'd22);
        for (int i = 0; i < 30; i++) begin
            cnt_in = (i % 2 == 1) ? 6'd21 : 6'd20;
            tick();
            n_cmp++;
            if (value !== 6'd22 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL unstable_hold: got value=%0d fault=%0b expected 22/0", value, fault);
            end
        end
        cnt_in = 6'd21;
        repeat (8) tick();
        n_cmp++;
        if (value !== 6'd21) begin
            n_fail++;
            $display("FAIL unstable_settle: got %0d expected 21", value);
        end
    endtask

    task automatic test_fault();
        do_preset(6'd30);
        cnt_in = 6'd35;
        repeat (8) tick();
        n_cmp++;
        if (fault !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL fault_flag: got fault=%0b state=%0d expected 1/2", fault, state);
        end
        n_cmp++;
        if (value !== 6'd30 || value_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_value: got value=%0d vv=%0b expected 30/0", value, value_valid);
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        n_cmp++;
        if (state !== 2'd0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: got state=%0d fault=%0b expected 0/0", state, fault);
        end
        tick();
        n_cmp++;
        if (state !== 2'd1 || value !== 6'd35 || value_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_reacquire: got state=%0d value=%0d vv=%0b expected 1/35/1",
                     state, value, value_valid);
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        n_cmp++;
        if (state !== 2'd1 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clr_ignored: got state=%0d fault=%0b expected 1/0", state, fault);
        end
    endtask

    task automatic test_wrap_saturate();
        int pulses1;
        int pulses2;
        int exp2;
        pulses1 = 0;
        pulses2 = 0;
        do_preset(6'd1);
        for (int w = 1; w <= 5; w++) begin
            cnt_in = 6'd63;
            repeat (5) begin
                tick();
                if (wrap_pulse)  pulses1++;
                if (wrap_pulse2) pulses2++;
            end
            exp2 = (w > 3) ? 3 : w;
            n_cmp++;
            if (wrap_count2 !== exp2[1:0] || wrap_count !== w[7:0]) begin
                n_fail++;
                $display("FAIL sat_count: got wc2=%0d wc=%0d expected %0d/%0d",
                         wrap_count2, wrap_count, exp2, w);
            end
            for (int v = 61; v >= 1; v -= 2) begin
                cnt_in = v[5:0];
                repeat (5) begin
                    tick();
                    if (wrap_pulse)  pulses1++;
                    if (wrap_pulse2) pulses2++;
                end
            end
        end
        n_cmp++;
        if (pulses2 != 5 || pulses1 != 5) begin
            n_fail++;
            $display("FAIL sat_pulses: got p2=%0d p1=%0d expected 5/5", pulses2, pulses1);
        end
        n_cmp++;
        if (fault2 !== 1'b0 || value2 !== 6'd1 || value_valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_state: got fault=%0b value=%0d vv=%0b expected 0/1/1",
                     fault2, value2, value_valid2);
        end
    endtask

    task automatic test_preset_abort();
        n_cmp++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_pre: got state=%0d expected 1", state);
        end
        #2;
        preset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 2'd0 || value !== 6'd0 || value_valid !== 1'b0 || wrap_count !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_async: got state=%0d value=%0d vv=%0b wc=%0d expected 0/0/0/0",
                     state, value, value_valid, wrap_count);
        end
        tick();
        preset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steps();
        test_wrap();
        test_unstable();
        test_fault();
        test_wrap_saturate();
        test_preset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
